ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX->MEM pipeline stage register for the MIPS core, with valid/ready flow control.

---
 rtl/ex_mem_pipe_reg.sv | 125 ++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake.
// A main entry drives the MEM-side outputs and a one-entry skid buffer
// absorbs the extra beat, so in_ready comes straight from a flop.
module ex_mem_pipe_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_add,
    input  logic              in_flag,
    input  logic [DATA_W-1:0] in_res,
    input  logic [DATA_W-1:0] in_dat2,
    input  logic [REG_W-1:0]  in_mux,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              ou_valid,
    input  logic              ou_ready,
    output logic [ADDR_W-1:0] ou_add,
    output logic              ou_flag,
    output logic [DATA_W-1:0] ou_res,
    output logic [DATA_W-1:0] ou_dat2,
    output logic [REG_W-1:0]  ou_mux,
    output logic [CTRL_W-1:0] ou_ctrl,
    output logic [1:0]        ou_count
);

    localparam int unsigned PW = ADDR_W + 1 + 2 * DATA_W + REG_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   in_pl;
    logic            push;
    logic            pop;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    assign in_pl = {in_add, in_flag, in_res, in_dat2, in_mux, in_ctrl};

    // Handshake decode, next occupancy state and payload load enables.
    always_comb begin
        push           = in_valid & in_ready;
        pop            = ou_valid & ou_ready;
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nx     = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nx       = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // Flush discards held entries and any accepted beat; payload stays put.
        if (flush) begin
            state_nx       = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State, registered in_ready and payload storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != FULL);
            if (load_main_in) begin
                main_q <= in_pl;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pl;
            end
        end
    end

    assign ou_valid = (state != EMPTY);
    assign ou_count = state;

    // Control bits are masked while empty so a bubble performs no writes.
    always_comb begin
        {ou_add, ou_flag, ou_res, ou_dat2, ou_mux} = main_q[PW-1:CTRL_W];
        ou_ctrl = ou_valid ? main_q[CTRL_W-1:0] : '0;
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed-vector bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_add;
    logic        in_flag;
    logic [31:0] in_res;
    logic [31:0] in_dat2;
    logic [4:0]  in_mux;
    logic [3:0]  in_ctrl;
    logic        ou_valid;
    logic        ou_ready;
    logic [31:0] ou_add;
    logic        ou_flag;
    logic [31:0] ou_res;
    logic [31:0] ou_dat2;
    logic [4:0]  ou_mux;
    logic [3:0]  ou_ctrl;
    logic [1:0]  ou_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(
        .ADDR_W(32),
        .DATA_W(32),
        .REG_W (5),
        .CTRL_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_add  (in_add),
        .in_flag (in_flag),
        .in_res  (in_res),
        .in_dat2 (in_dat2),
        .in_mux  (in_mux),
        .in_ctrl (in_ctrl),
        .ou_valid(ou_valid),
        .ou_ready(ou_ready),
        .ou_add  (ou_add),
        .ou_flag (ou_flag),
        .ou_res  (ou_res),
        .ou_dat2 (ou_dat2),
        .ou_mux  (ou_mux),
        .ou_ctrl (ou_ctrl),
        .ou_count(ou_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, ".ou_valid"}, 64'(ou_valid), 64'd0);
        check_eq({pfx, ".ou_count"}, 64'(ou_count), 64'd0);
        check_eq({pfx, ".in_ready"}, 64'(in_ready), 64'd1);
        check_eq({pfx, ".ou_add"},   64'(ou_add),   64'd0);
        check_eq({pfx, ".ou_flag"},  64'(ou_flag),  64'd0);
        check_eq({pfx, ".ou_res"},   64'(ou_res),   64'd0);
        check_eq({pfx, ".ou_dat2"},  64'(ou_dat2),  64'd0);
        check_eq({pfx, ".ou_mux"},   64'(ou_mux),   64'd0);
        check_eq({pfx, ".ou_ctrl"},  64'(ou_ctrl),  64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        ou_ready = 1'b0;
        in_add   = 32'h0;
        in_flag  = 1'b0;
        in_res   = 32'h0;
        in_dat2  = 32'h0;
        in_mux   = 5'd0;
        in_ctrl  = 4'b0;

        // Reset held for two cycles.
        tick;
        tick;
        check_reset_state("rst");

        // Pass-through with single-cycle latency.
        rst_n    = 1'b1;
        ou_ready = 1'b1;
        in_valid = 1'b1;
        in_add   = 32'h0000_0100;
        in_flag  = 1'b1;
        in_res   = 32'h0000_1234;
        in_dat2  = 32'hDEAD_BEEF;
        in_mux   = 5'd9;
        in_ctrl  = 4'b1000;
        tick;
        check_eq("pt.ou_valid", 64'(ou_valid), 64'd1);
        check_eq("pt.ou_res",   64'(ou_res),   64'h1234);
        check_eq("pt.ou_mux",   64'(ou_mux),   64'd9);
        check_eq("pt.ou_ctrl",  64'(ou_ctrl),  64'b1000);
        check_eq("pt.ou_add",   64'(ou_add),   64'h100);
        check_eq("pt.ou_flag",  64'(ou_flag),  64'd1);
        check_eq("pt.ou_dat2",  64'(ou_dat2),  64'hDEAD_BEEF);
        check_eq("pt.ou_count", 64'(ou_count), 64'd1);
        in_valid = 1'b0;
        tick;
        check_eq("bub.ou_valid", 64'(ou_valid), 64'd0);
        check_eq("bub.ou_ctrl",  64'(ou_ctrl),  64'd0);
        check_eq("bub.ou_res",   64'(ou_res),   64'h1234);
        check_eq("bub.ou_mux",   64'(ou_mux),   64'd9);

        // Backpressure fills the skid entry.
        ou_ready = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 4'b0100;
        in_res   = 32'hA;
        tick;
        check_eq("bp1.in_ready", 64'(in_ready), 64'd1);
        in_res = 32'hB;
        tick;
        check_eq("bp2.ou_count", 64'(ou_count), 64'd2);
        check_eq("bp2.in_ready", 64'(in_ready), 64'd0);
        check_eq("bp2.ou_res",   64'(ou_res),   64'hA);
        in_valid = 1'b0;
        tick;
        check_eq("bp3.ou_res",   64'(ou_res),   64'hA);
        check_eq("bp3.ou_count", 64'(ou_count), 64'd2);
        ou_ready = 1'b1;
        tick;
        check_eq("bp4.ou_res",   64'(ou_res),   64'hB);
        check_eq("bp4.in_ready", 64'(in_ready), 64'd1);
        check_eq("bp4.ou_count", 64'(ou_count), 64'd1);
        tick;
        check_eq("bp5.ou_count", 64'(ou_count), 64'd0);

        // Streaming with simultaneous push and pop.
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_res = 32'(i);
            tick;
            check_eq($sformatf("st%0d.ou_res", i),   64'(ou_res),   64'(i));
            check_eq($sformatf("st%0d.ou_count", i), 64'(ou_count), 64'd1);
        end
        in_valid = 1'b0;
        tick;
        check_eq("st.drain", 64'(ou_count), 64'd0);

        // Flush while full and offering a new beat.
        ou_ready = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 4'b0001;
        in_res   = 32'hC1;
        tick;
        in_res = 32'hC2;
        tick;
        check_eq("fl.full", 64'(ou_count), 64'd2);
        flush  = 1'b1;
        in_res = 32'hC3;
        tick;
        check_eq("fl.ou_valid", 64'(ou_valid), 64'd0);
        check_eq("fl.ou_ctrl",  64'(ou_ctrl),  64'd0);
        check_eq("fl.ou_count", 64'(ou_count), 64'd0);
        check_eq("fl.in_ready", 64'(in_ready), 64'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        ou_ready = 1'b1;
        tick;
        check_eq("fl.stay_empty", 64'(ou_valid), 64'd0);
        in_valid = 1'b1;
        in_res   = 32'hD1;
        tick;
        check_eq("fl.next_res",   64'(ou_res),   64'hD1);
        check_eq("fl.next_count", 64'(ou_count), 64'd1);

        // Flush drops an accepted beat while one entry is held.
        ou_ready = 1'b0;
        flush    = 1'b1;
        in_res   = 32'hE1;
        tick;
        check_eq("fl2.ou_count", 64'(ou_count), 64'd0);
        check_eq("fl2.ou_res",   64'(ou_res),   64'hD1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick;
        check_eq("fl2.ou_valid", 64'(ou_valid), 64'd0);

        // Reset while full and still pushing.
        in_valid = 1'b1;
        in_ctrl  = 4'b1111;
        in_mux   = 5'd31;
        in_res   = 32'hF1;
        tick;
        in_res = 32'hF2;
        tick;
        check_eq("mr.full", 64'(ou_count), 64'd2);
        rst_n  = 1'b0;
        in_res = 32'hF3;
        tick;
        check_reset_state("mr");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick;
        check_reset_state("mr.post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
